// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C transaction sequencer: FSM state codes,
// command-phase codes and engine word bit positions.
package i2c_seq_pkg;

  // Sequencer FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_WAIT_BUSY = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_NEXT      = 3'd4;
  localparam state_t ST_FETCH     = 3'd5;
  localparam state_t ST_ABORT     = 3'd6;

  // Which word of the transaction is currently on the bus
  typedef logic [1:0] phase_t;
  localparam phase_t PH_ADDR  = 2'd0;  // START + device address (write direction)
  localparam phase_t PH_REG   = 2'd1;  // register address
  localparam phase_t PH_RADDR = 2'd2;  // repeated START + device address (read)
  localparam phase_t PH_DATA  = 2'd3;  // data bytes

  // Engine word layout
  localparam int START_BIT = 15;
  localparam int STOP_BIT  = 14;
  localparam int ACK_BIT   = 8;

  // Released ack slot, all-ones data, STOP: terminates the bus after a NACK
  localparam logic [15:0] ABORT_WORD = 16'h41FF;

endpackage

// File: rtl/i2c_txn_sequencer.sv
// Turns one register-access command into the ordered engine words
// (START, address, register, repeated START, data, STOP), handshakes each
// byte with the engine and streams write/read data.
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_dev,
  input  logic [7:0]       cmd_reg,
  input  logic             cmd_rnw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             nack_err,
  output logic             eng_strobe,
  output logic [15:0]      eng_word,
  input  logic [8:0]       eng_rd,
  input  logic [7:0]       eng_state
);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic             rnw_q, rnw_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      word_q, word_d;
  logic             abort_q, abort_d;
  logic [8:0]       res_q, res_d;
  logic             wr_ready_q, wr_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;

  logic             checked;
  logic             rd_byte;

  // Assembles one engine word from its fields
  function automatic logic [15:0] make_word(input logic start, input logic stop,
                                            input logic ack, input logic [7:0] data);
    logic [15:0] w;
    w            = '0;
    w[START_BIT] = start;
    w[STOP_BIT]  = stop;
    w[ACK_BIT]   = ack;
    w[7:0]       = data;
    return w;
  endfunction

  // The slave drives the ack slot on every byte except read data
  assign checked = !(rnw_q && (phase_q == PH_DATA));
  assign rd_byte = rnw_q && (phase_q == PH_DATA) && !abort_q;

  // Next-state and output-pulse logic
  always_comb begin
    // NOTE: every _d starts from its register (pulses from 0) so no path through the case can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    rnw_d      = rnw_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    abort_d    = abort_q;
    res_d      = res_q;
    rd_data_d  = rd_data_q;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    nack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          rnw_d   = cmd_rnw;
          // a zero-length read still fetches one byte
          cnt_d   = (cmd_rnw && (cmd_len == '0)) ? LEN_W'(1) : cmd_len;
          phase_d = PH_ADDR;
          abort_d = 1'b0;
          word_d  = make_word(1'b1, 1'b0, 1'b0, {cmd_dev, 1'b0});
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: state_d = ST_WAIT_BUSY;

      ST_WAIT_BUSY: begin
        if (eng_state != 8'd0) state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (eng_state == 8'd0) begin
          res_d   = eng_rd;
          state_d = ST_NEXT;
          // a STOP word ends the transaction whatever the slave answered
          if (word_q[STOP_BIT]) begin
            done_d = 1'b1;
            nack_d = abort_q || (checked && eng_rd[ACK_BIT]);
          end
        end
      end

      ST_NEXT: begin
        if (rd_byte) begin
          rd_valid_d = 1'b1;
          rd_data_d  = res_q[7:0];
        end
        if (abort_q || word_q[STOP_BIT]) begin
          state_d = ST_IDLE;
        end else if (checked && res_q[ACK_BIT]) begin
          state_d = ST_ABORT;
        end else begin
          case (phase_q)
            PH_ADDR: begin
              phase_d = PH_REG;
              word_d  = make_word(1'b0, !rnw_q && (cnt_q == '0), 1'b1, reg_q);
              state_d = ST_LOAD;
            end
            PH_REG: begin
              if (rnw_q) begin
                phase_d = PH_RADDR;
                word_d  = make_word(1'b1, 1'b0, 1'b0, {dev_q, 1'b1});
                state_d = ST_LOAD;
              end else begin
                phase_d = PH_DATA;
                state_d = ST_FETCH;
              end
            end
            PH_RADDR: begin
              phase_d = PH_DATA;
              word_d  = make_word(1'b0, cnt_q == LEN_W'(1), cnt_q == LEN_W'(1), 8'hFF);
              state_d = ST_LOAD;
            end
            default: begin
              // one data byte finished; the next one is last when two remained
              cnt_d = cnt_q - LEN_W'(1);
              if (rnw_q) begin
                word_d  = make_word(1'b0, cnt_q == LEN_W'(2), cnt_q == LEN_W'(2), 8'hFF);
                state_d = ST_LOAD;
              end else begin
                state_d = ST_FETCH;
              end
            end
          endcase
        end
      end

      ST_FETCH: begin
        // hold the bus (no strobe) until the host supplies the byte
        if (wr_valid) begin
          word_d     = make_word(1'b0, cnt_q == LEN_W'(1), 1'b1, wr_data);
          wr_ready_d = 1'b1;
          state_d    = ST_LOAD;
        end
      end

      ST_ABORT: begin
        word_d  = ABORT_WORD;
        abort_d = 1'b1;
        state_d = ST_LOAD;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ADDR;
      dev_q      <= '0;
      reg_q      <= '0;
      rnw_q      <= 1'b0;
      cnt_q      <= '0;
      word_q     <= '0;
      abort_q    <= 1'b0;
      res_q      <= '0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      phase_q    <= phase_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      rnw_q      <= rnw_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      abort_q    <= abort_d;
      res_q      <= res_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  // Engine must be idle before a new command may start the bus again
  assign cmd_ready  = !rst && (state_q == ST_IDLE) && (eng_state == 8'd0);
  assign eng_strobe = (state_q == ST_LOAD);
  assign eng_word   = word_q;
  assign wr_ready   = wr_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign nack_err   = nack_q;

endmodule
